memory_access: RTL and testbench
================================

# memory_access

Memory stage of the five-stage MIPS pipeline, downstream of the execution stage. It consumes the execute/memory pipeline signals (ALU result, destination register, write enable, memory controls), performs word loads and stores against an internal data memory with configurable access latency, and registers the memory/writeback pipeline signals. It stalls upstream stages while a multi-cycle access is in flight and flags misaligned, out-of-range or conflicting accesses.

## Interface
- MEM_DEPTH, 128: data memory size in 32-bit words; power of two, at least 4.
- MEM_LATENCY, 2: access latency; number of cycles mem_stall is high per access; legal range 1..7.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- ALUout  input  32  byte address for loads/stores; pass-through result otherwise.
- XM_B  input  32  store data.
- XM_RD  input  5  destination register.
- XM_RegWrite  input  1  instruction writes the register file.
- XM_MemRead  input  1  load word.
- XM_MemWrite  input  1  store word.
- MW_Data  output  32  writeback data: load data or ALUout.
- MW_RD  output  5  registered destination register.
- MW_RegWrite  output  1  registered write enable; 0 for bubbles and faults.
- MW_Fault  output  1  one-cycle pulse on a rejected access.
- mem_stall  output  1  combinational; upstream holds all X* inputs stable while high.

## Operation
- An access is present when XM_MemRead or XM_MemWrite is 1.
- Word index is ALUout[log2(MEM_DEPTH)+1:2].
- The access is invalid when any of these holds: ALUout[1:0] != 0; ALUout[31:2] >= MEM_DEPTH; XM_MemRead and XM_MemWrite are both 1.
- FSM states: IDLE and BUSY, plus a 3-bit counter cnt.
- IDLE, no access:
  - Next edge: MW_Data <= ALUout, MW_RD <= XM_RD, MW_RegWrite <= XM_RegWrite, MW_Fault <= 0.
  - No stall.
- IDLE, invalid access:
  - Next edge: MW_Fault <= 1, MW_RegWrite <= 0, MW_RD <= XM_RD, MW_Data <= ALUout.
  - No memory write, no stall, stay in IDLE.
- IDLE, valid access:
  - mem_stall = 1.
  - Next edge: go to BUSY, cnt <= MEM_LATENCY-1, MW_RegWrite <= 0 (bubble), MW_Fault <= 0.
- BUSY, cnt != 0:
  - mem_stall = 1.
  - cnt decrements each edge; MW_RegWrite <= 0.
- BUSY, cnt == 0:
  - mem_stall = 0.
  - Next edge, store: mem[index] <= XM_B, MW_RegWrite <= 0.
  - Next edge, load: MW_Data <= mem[index], MW_RegWrite <= XM_RegWrite.
  - Both cases: MW_RD <= XM_RD, go to IDLE.
  - Upstream advances on this same edge, so the held access is never accepted twice.
- Memory contents are not cleared by rst; simulation initialises every word to 0.
- Inputs that change while mem_stall is high are a protocol violation; the FSM samples the address and data only at completion.

## Timing
- Reset values: MW_Data = 0, MW_RD = 0, MW_RegWrite = 0, MW_Fault = 0, state = IDLE, cnt = 0, mem_stall = 0 (IDLE with no access).
- rst during BUSY:
  - The next edge returns the block to IDLE.
  - A pending store is discarded; memory is unchanged.
  - All outputs take their reset values.
- Non-memory instruction: 1-cycle latency, input edge to MW_* valid.
- Valid access:
  - Occupies MEM_LATENCY+1 cycles.
  - mem_stall is high for exactly MEM_LATENCY consecutive cycles, starting in the cycle the access is first presented.
  - Result (or write commit) appears on the edge ending the first cycle with mem_stall low.
- Back-to-back accesses:
  - The second access is presented in the cycle after completion; IDLE accepts it immediately.
  - No dead cycle between accesses beyond the bubble.
- Invalid access: MW_Fault is high for exactly the one cycle after the edge; never stalls.

## Test plan
- Reset: assert rst for 2 cycles mid-BUSY store to address 0x10 with XM_B = 0xDEADBEEF -> all outputs 0, IDLE; a later load of 0x10 returns 0.
- Pass-through: ALUout = 0x12345678, XM_RD = 7, XM_RegWrite = 1, no access -> next cycle MW_Data = 0x12345678, MW_RD = 7, MW_RegWrite = 1, mem_stall = 0 throughout.
- Store then load at MEM_LATENCY = 2:
  - Store 0xCAFEF00D to 0x20 -> mem_stall high for 2 cycles, MW_RegWrite = 0.
  - Load 0x20, XM_RD = 9 -> mem_stall high for 2 cycles, then MW_Data = 0xCAFEF00D, MW_RD = 9, MW_RegWrite = 1.
- Latency sweep: MEM_LATENCY = 1 and 7 -> stall-high counts of 1 and 7; total cycles per access 2 and 8.
- Faults -> each gives a single MW_Fault pulse, MW_RegWrite = 0, mem_stall = 0, memory unchanged. Cases:
  - load at 0x22 (misaligned);
  - store at 4*MEM_DEPTH (out of range);
  - MemRead = MemWrite = 1 at 0x0.
- Back-to-back: store 0x1 to 0x0, then store 0x2 to 0x4, then load 0x4, with no gaps -> stall pattern repeats exactly per access; load returns 0x2.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage of the five-stage MIPS pipeline: word loads/stores against an
// internal data memory with fixed access latency, plus MEM/WB pipeline registers.
module memory_access #(
   parameter int MEM_DEPTH   = 128,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUout,
   input  logic [31:0] XM_B,
   input  logic [4:0]  XM_RD,
   input  logic        XM_RegWrite,
   input  logic        XM_MemRead,
   input  logic        XM_MemWrite,
   output logic [31:0] MW_Data,
   output logic [4:0]  MW_RD,
   output logic        MW_RegWrite,
   output logic        MW_Fault,
   output logic        mem_stall
);

   localparam int         AW     = $clog2(MEM_DEPTH);
   localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] mw_data_q, mw_data_d;
   logic [4:0]  mw_rd_q, mw_rd_d;
   logic        mw_regwrite_q, mw_regwrite_d;
   logic        mw_fault_q, mw_fault_d;
   logic        mem_we;
   logic        access;
   logic        invalid;
   logic [AW-1:0] idx;
   logic [31:0] rdata_q;
   logic [31:0] mem_q [MEM_DEPTH];

   assign access  = XM_MemRead | XM_MemWrite;
   assign idx     = ALUout[AW+1:2];
   // Any set bit above the index field means the word address is past the end.
   assign invalid = (ALUout[1:0] != 2'b00) | (|ALUout[31:AW+2]) | (XM_MemRead & XM_MemWrite);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= 3'd0;
         mw_data_q     <= 32'd0;
         mw_rd_q       <= 5'd0;
         mw_regwrite_q <= 1'b0;
         mw_fault_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mw_data_q     <= mw_data_d;
         mw_rd_q       <= mw_rd_d;
         mw_regwrite_q <= mw_regwrite_d;
         mw_fault_q    <= mw_fault_d;
      end
   end

   // Registered read: the address is held stable for at least one stall cycle,
   // so rdata_q already holds the addressed word by the completion cycle.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[idx] <= XM_B;
      end
      rdata_q <= mem_q[idx];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (access && !invalid) begin
               state_d = BUSY;
               cnt_d   = LAT_M1;
            end
         end
         BUSY: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mw_data_d     = mw_data_q;
      mw_rd_d       = mw_rd_q;
      mw_regwrite_d = 1'b0;
      mw_fault_d    = 1'b0;
      mem_we        = 1'b0;
      mem_stall     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!access) begin
               mw_data_d     = ALUout;
               mw_rd_d       = XM_RD;
               mw_regwrite_d = XM_RegWrite;
            end else if (invalid) begin
               mw_data_d  = ALUout;
               mw_rd_d    = XM_RD;
               mw_fault_d = 1'b1;
            end else begin
               mem_stall = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q != 3'd0) begin
               mem_stall = 1'b1;
            end else begin
               mw_rd_d = XM_RD;
               if (XM_MemWrite) begin
                  mem_we = 1'b1;
               end else begin
                  mw_data_d     = rdata_q;
                  mw_regwrite_d = XM_RegWrite;
               end
            end
         end
         default: mem_stall = 1'b0;
      endcase
   end

   assign MW_Data     = mw_data_q;
   assign MW_RD       = mw_rd_q;
   assign MW_RegWrite = mw_regwrite_q;
   assign MW_Fault    = mw_fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: main instance at latency 2, plus latency 1
// and 7 instances sharing the same inputs for the latency sweep.
module tb_memory_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUout;
   logic [31:0] XM_B;
   logic [4:0]  XM_RD;
   logic        XM_RegWrite;
   logic        XM_MemRead;
   logic        XM_MemWrite;

   logic [31:0] mw_data, mw_data_l1, mw_data_l7;
   logic [4:0]  mw_rd, mw_rd_l1, mw_rd_l7;
   logic        mw_rw, mw_rw_l1, mw_rw_l7;
   logic        mw_fault, mw_fault_l1, mw_fault_l7;
   logic        stall, stall_l1, stall_l7;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memory_access #(.MEM_DEPTH(128), .MEM_LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .ALUout(ALUout), .XM_B(XM_B), .XM_RD(XM_RD),
      .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
      .MW_Data(mw_data), .MW_RD(mw_rd), .MW_RegWrite(mw_rw), .MW_Fault(mw_fault),
      .mem_stall(stall)
   );

   memory_access #(.MEM_DEPTH(128), .MEM_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .ALUout(ALUout), .XM_B(XM_B), .XM_RD(XM_RD),
      .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
      .MW_Data(mw_data_l1), .MW_RD(mw_rd_l1), .MW_RegWrite(mw_rw_l1), .MW_Fault(mw_fault_l1),
      .mem_stall(stall_l1)
   );

   memory_access #(.MEM_DEPTH(128), .MEM_LATENCY(7)) u_lat7 (
      .clk(clk), .rst(rst), .ALUout(ALUout), .XM_B(XM_B), .XM_RD(XM_RD),
      .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
      .MW_Data(mw_data_l7), .MW_RD(mw_rd_l7), .MW_RegWrite(mw_rw_l7), .MW_Fault(mw_fault_l7),
      .mem_stall(stall_l7)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] b, input logic [4:0] dst, input logic rw);
      XM_MemRead  = rd;
      XM_MemWrite = wr;
      ALUout      = addr;
      XM_B        = b;
      XM_RD       = dst;
      XM_RegWrite = rw;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   // Valid access on the latency-2 instance: two stall cycles with bubbles,
   // one stall-free completion cycle; returns just after the completion edge.
   task automatic do_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] b,
                            input logic [4:0] dst, input logic rw);
      drive(rd, wr, addr, b, dst, rw);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk({tag, " stall_hi"}, stall, 1);
         next_edge();
         chk({tag, " bubble"}, mw_rw, 0);
         chk({tag, " nofault"}, mw_fault, 0);
      end
      @(negedge clk);
      chk({tag, " stall_lo"}, stall, 0);
      next_edge();
      chk({tag, " rd"}, mw_rd, dst);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int low1, low7, done1, done7;

      rst = 1'b1;
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      next_edge();
      next_edge();
      rst = 1'b0;
      @(negedge clk);
      chk("reset data", mw_data, 32'h0);
      chk("reset rd", mw_rd, 0);
      chk("reset rw", mw_rw, 0);
      chk("reset fault", mw_fault, 0);
      chk("reset stall", stall, 0);

      // Pass-through of a non-memory instruction.
      next_edge();
      drive(0, 0, 32'h12345678, 32'h0, 5'd7, 1);
      @(negedge clk);
      chk("pass stall", stall, 0);
      next_edge();
      chk("pass data", mw_data, 32'h12345678);
      chk("pass rd", mw_rd, 7);
      chk("pass rw", mw_rw, 1);
      chk("pass fault", mw_fault, 0);

      // Known contents at 0x10, then a store to it interrupted by reset.
      do_access("pre_st10", 0, 1, 32'h10, 32'h0, 5'd0, 0);
      drive(0, 1, 32'h10, 32'hDEADBEEF, 5'd4, 0);
      @(negedge clk);
      chk("rst_st stall", stall, 1);
      next_edge();
      rst = 1'b1;
      next_edge();
      chk("rst_mid rw", mw_rw, 0);
      chk("rst_mid rd", mw_rd, 0);
      next_edge();
      rst = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      @(negedge clk);
      chk("rst_busy stall", stall, 0);
      chk("rst_busy data", mw_data, 32'h0);
      chk("rst_busy rd", mw_rd, 0);
      chk("rst_busy rw", mw_rw, 0);
      chk("rst_busy fault", mw_fault, 0);
      next_edge();
      do_access("ld10", 1, 0, 32'h10, 32'h0, 5'd2, 1);
      chk("ld10 data", mw_data, 32'h0);
      chk("ld10 rw", mw_rw, 1);

      // Store then load.
      do_access("st20", 0, 1, 32'h20, 32'hCAFEF00D, 5'd0, 0);
      chk("st20 rw", mw_rw, 0);
      do_access("ld20", 1, 0, 32'h20, 32'h0, 5'd9, 1);
      chk("ld20 data", mw_data, 32'hCAFEF00D);
      chk("ld20 rw", mw_rw, 1);

      // Faults; word 0 holds a known value so rejected stores are visible.
      do_access("st00", 0, 1, 32'h0, 32'h00000077, 5'd0, 0);
      drive(1, 0, 32'h22, 32'h0, 5'd3, 1);
      @(negedge clk);
      chk("mis stall", stall, 0);
      next_edge();
      chk("mis fault", mw_fault, 1);
      chk("mis rw", mw_rw, 0);
      chk("mis rd", mw_rd, 3);
      chk("mis data", mw_data, 32'h22);
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      next_edge();
      chk("mis pulse_end", mw_fault, 0);

      drive(0, 1, 32'h200, 32'hBAD0BAD0, 5'd6, 1);
      @(negedge clk);
      chk("oor stall", stall, 0);
      next_edge();
      chk("oor fault", mw_fault, 1);
      chk("oor rw", mw_rw, 0);
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      next_edge();
      chk("oor pulse_end", mw_fault, 0);

      drive(1, 1, 32'h0, 32'hBAD1BAD1, 5'd8, 1);
      @(negedge clk);
      chk("rdwr stall", stall, 0);
      next_edge();
      chk("rdwr fault", mw_fault, 1);
      chk("rdwr rw", mw_rw, 0);
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      next_edge();
      chk("rdwr pulse_end", mw_fault, 0);

      do_access("ld00", 1, 0, 32'h0, 32'h0, 5'd10, 1);
      chk("ld00 unchanged", mw_data, 32'h00000077);
      do_access("ld20b", 1, 0, 32'h20, 32'h0, 5'd11, 1);
      chk("ld20b unchanged", mw_data, 32'hCAFEF00D);

      // Back-to-back accesses with no idle gap.
      do_access("b2b st0", 0, 1, 32'h0, 32'h1, 5'd0, 0);
      do_access("b2b st4", 0, 1, 32'h4, 32'h2, 5'd0, 0);
      do_access("b2b ld4", 1, 0, 32'h4, 32'h0, 5'd12, 1);
      chk("b2b ld4 data", mw_data, 32'h2);
      chk("b2b ld4 rw", mw_rw, 1);
      do_access("b2b ld0", 1, 0, 32'h0, 32'h0, 5'd13, 1);
      chk("b2b ld0 data", mw_data, 32'h1);

      // Latency sweep: cycle index of first stall-low and of the result edge.
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      rst = 1'b1;
      next_edge();
      rst = 1'b0;
      low1 = 0; low7 = 0; done1 = 0; done7 = 0;
      drive(1, 0, 32'h8, 32'h0, 5'd5, 1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (!stall_l1 && low1 == 0) low1 = c;
         if (!stall_l7 && low7 == 0) low7 = c;
         next_edge();
         if (mw_rw_l1 && done1 == 0) done1 = c;
         if (mw_rw_l7 && done7 == 0) done7 = c;
      end
      chk("lat1 stall_cycles", 32'(low1 - 1), 32'd1);
      chk("lat7 stall_cycles", 32'(low7 - 1), 32'd7);
      chk("lat1 total_cycles", 32'(done1), 32'd2);
      chk("lat7 total_cycles", 32'(done7), 32'd8);

      drive(0, 0, 32'h0, 32'h0, 5'd0, 0);
      next_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
